rob_wide: RTL and testbench

Parametrised reorder buffer for the out-of-order RISC-V core, replacing the single-commit ROB. It sits between dispatcher, ALU/LSB result buses, register file, LSB and branch predictor. It keeps up to DEPTH-1 in-flight instructions, retires up to two in order per cycle, and forwards CDB results to operand queries in the same cycle. It raises a registered rollback on branch mispredict.

---
 rtl/rob_wide_if.sv | 87 ++++++++
 rtl/rob_wide.sv | 150 +++++++++++++++
 tb/tb_rob_wide.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_wide_if.sv
// rob_wide_if: bundle of every ROB-facing signal except clk/rst.
//   slave  : ROB side (receives dispatch, queries, CDB; drives status/commit)
//   master : surrounding core side (dispatcher, ALU/LSB, regfile, predictor)
//   rdy    : global enable, owned by the core
interface rob_wide_if #(
    parameter int unsigned IDW = 4
);
    logic            rdy;

    // Dispatch / allocation
    logic            rob_full;
    logic [IDW-1:0]  rob_count;
    logic            dsp_valid;
    logic [31:0]     dsp_pc;
    logic [4:0]      dsp_rd;
    logic            dsp_is_jump;
    logic            dsp_pred_taken;
    logic            dsp_is_store;
    logic [IDW-1:0]  dsp_alias;

    // Operand queries
    logic [IDW-1:0]  q1_alias;
    logic [IDW-1:0]  q2_alias;
    logic            q1_rdy;
    logic            q2_rdy;
    logic [31:0]     q1_val;
    logic [31:0]     q2_val;

    // Result buses
    logic            alu_valid;
    logic [IDW-1:0]  alu_alias;
    logic [31:0]     alu_val;
    logic            alu_taken;
    logic [31:0]     alu_target;
    logic            lsb_valid;
    logic [IDW-1:0]  lsb_alias;
    logic [31:0]     lsb_val;

    // Store handshake with the LSB
    logic            store_at_head;
    logic [IDW-1:0]  head_alias;

    // Commit to the register file
    logic            wb0_valid;
    logic [4:0]      wb0_rd;
    logic [31:0]     wb0_val;
    logic [IDW-1:0]  wb0_alias;
    logic            wb1_valid;
    logic [4:0]      wb1_rd;
    logic [31:0]     wb1_val;
    logic [IDW-1:0]  wb1_alias;

    // Predictor update and redirect
    logic            pred_en;
    logic            pred_taken;
    logic [31:0]     pred_pc;
    logic            rollback;
    logic [31:0]     rollback_pc;

    modport slave (
        input  rdy,
        input  dsp_valid, dsp_pc, dsp_rd, dsp_is_jump, dsp_pred_taken, dsp_is_store,
        input  q1_alias, q2_alias,
        input  alu_valid, alu_alias, alu_val, alu_taken, alu_target,
        input  lsb_valid, lsb_alias, lsb_val,
        output rob_full, rob_count, dsp_alias,
        output q1_rdy, q2_rdy, q1_val, q2_val,
        output store_at_head, head_alias,
        output wb0_valid, wb0_rd, wb0_val, wb0_alias,
        output wb1_valid, wb1_rd, wb1_val, wb1_alias,
        output pred_en, pred_taken, pred_pc, rollback, rollback_pc
    );

    modport master (
        output rdy,
        output dsp_valid, dsp_pc, dsp_rd, dsp_is_jump, dsp_pred_taken, dsp_is_store,
        output q1_alias, q2_alias,
        output alu_valid, alu_alias, alu_val, alu_taken, alu_target,
        output lsb_valid, lsb_alias, lsb_val,
        input  rob_full, rob_count, dsp_alias,
        input  q1_rdy, q2_rdy, q1_val, q2_val,
        input  store_at_head, head_alias,
        input  wb0_valid, wb0_rd, wb0_val, wb0_alias,
        input  wb1_valid, wb1_rd, wb1_val, wb1_alias,
        input  pred_en, pred_taken, pred_pc, rollback, rollback_pc
    );
endinterface

// File: rtl/rob_wide.sv
// rob_wide: dual-commit reorder buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rob_wide_if.slave -- dispatch/alloc, operand queries with CDB
//              bypass, ALU/LSB result buses, store-at-head, two registered
//              commit slots, predictor update and registered rollback.
// Entry 0 is reserved as "no alias"; live entries circulate over 1..DEPTH-1.
module rob_wide #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    rob_wide_if.slave   bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam logic [IDW-1:0] LAST  = IDW'(DEPTH - 1);
    localparam logic [IDW-1:0] FIRST = IDW'(1);

    logic [IDW-1:0]  head, tail, count;
    logic [DEPTH-1:0] ready;

    logic [XLEN-1:0] e_pc     [DEPTH];
    logic [XLEN-1:0] e_val    [DEPTH];
    logic [XLEN-1:0] e_target [DEPTH];
    logic [RW-1:0]   e_rd     [DEPTH];
    logic [DEPTH-1:0] e_jump, e_pred, e_taken, e_store;

    logic [IDW-1:0]  head1_c, jidx_c;
    logic            alloc_c, commit0_c, commit1_c, jump_c, mis_c, wb0_keep_c;
    logic [DEPTH-1:0] ready_nxt_c;
    logic [XLEN:0]   q1_c, q2_c;

    // Circular increment skipping the reserved entry 0
    function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] x);
        return (x == LAST) ? FIRST : x + FIRST;
    endfunction

    // Query result {rdy, val}: ALU bypass, then LSB bypass, then stored entry
    function automatic logic [XLEN:0] lookup(input logic [IDW-1:0] a);
        if (a == '0)
            return '0;
        else if (bus.alu_valid && bus.alu_alias == a)
            return {1'b1, bus.alu_val};
        else if (bus.lsb_valid && bus.lsb_alias == a)
            return {1'b1, bus.lsb_val};
        else
            return {ready[a], e_val[a]};
    endfunction

    assign bus.rob_full      = (count == LAST);
    assign bus.rob_count     = count;
    assign bus.dsp_alias     = tail;
    assign bus.head_alias    = head;
    assign bus.store_at_head = (count != '0) && e_store[head];
    assign bus.q1_rdy        = q1_c[XLEN];
    assign bus.q1_val        = q1_c[XLEN-1:0];
    assign bus.q2_rdy        = q2_c[XLEN];
    assign bus.q2_val        = q2_c[XLEN-1:0];

    // Commit selection, allocation and next ready vector
    always_comb begin
        q1_c      = lookup(bus.q1_alias);
        q2_c      = lookup(bus.q2_alias);
        head1_c   = inc(head);
        alloc_c   = bus.dsp_valid && !bus.rob_full && !bus.rollback;
        commit0_c = (count != '0) && ready[head];
        // A jump at head keeps slot 1 idle: one jump per cycle, and a
        // mispredicted head must not retire anything younger.
        commit1_c = commit0_c && (count >= IDW'(2)) && ready[head1_c] && !e_jump[head];
        jump_c    = (commit0_c && e_jump[head]) || (commit1_c && e_jump[head1_c]);
        jidx_c    = (commit0_c && e_jump[head]) ? head : head1_c;
        mis_c     = jump_c && (e_taken[jidx_c] != e_pred[jidx_c]);
        // Same rd in both slots: only the younger value reaches the regfile
        wb0_keep_c = !(commit1_c && (e_rd[head1_c] == e_rd[head]));

        ready_nxt_c = ready;
        if (commit0_c) ready_nxt_c[head]    = 1'b0;
        if (commit1_c) ready_nxt_c[head1_c] = 1'b0;
        if (alloc_c)   ready_nxt_c[tail]    = 1'b0;
        if (bus.lsb_valid && bus.lsb_alias != '0) ready_nxt_c[bus.lsb_alias] = 1'b1;
        if (bus.alu_valid && bus.alu_alias != '0) ready_nxt_c[bus.alu_alias] = 1'b1;
    end

    // Pointers, ready flags and registered commit outputs; rollback acts as reset
    always_ff @(posedge clk) begin
        if (rst || (bus.rdy && bus.rollback)) begin
            head            <= FIRST;
            tail            <= FIRST;
            count           <= '0;
            ready           <= '0;
            bus.wb0_valid   <= 1'b0;
            bus.wb0_rd      <= '0;
            bus.wb0_val     <= '0;
            bus.wb0_alias   <= '0;
            bus.wb1_valid   <= 1'b0;
            bus.wb1_rd      <= '0;
            bus.wb1_val     <= '0;
            bus.wb1_alias   <= '0;
            bus.pred_en     <= 1'b0;
            bus.pred_taken  <= 1'b0;
            bus.pred_pc     <= '0;
            bus.rollback    <= 1'b0;
            bus.rollback_pc <= '0;
        end else if (bus.rdy) begin
            tail  <= alloc_c ? inc(tail) : tail;
            head  <= commit1_c ? inc(head1_c) : (commit0_c ? head1_c : head);
            count <= count + IDW'(alloc_c) - IDW'(commit0_c) - IDW'(commit1_c);
            ready <= ready_nxt_c;

            bus.wb0_valid <= commit0_c && (e_rd[head] != '0) && wb0_keep_c;
            bus.wb0_rd    <= commit0_c ? e_rd[head]  : '0;
            bus.wb0_val   <= commit0_c ? e_val[head] : '0;
            bus.wb0_alias <= commit0_c ? head        : '0;
            bus.wb1_valid <= commit1_c && (e_rd[head1_c] != '0);
            bus.wb1_rd    <= commit1_c ? e_rd[head1_c]  : '0;
            bus.wb1_val   <= commit1_c ? e_val[head1_c] : '0;
            bus.wb1_alias <= commit1_c ? head1_c        : '0;

            bus.pred_en     <= jump_c;
            bus.pred_taken  <= jump_c && (e_taken[jidx_c] == e_pred[jidx_c]);
            bus.pred_pc     <= jump_c ? e_pc[jidx_c] : '0;
            bus.rollback    <= mis_c;
            bus.rollback_pc <= !mis_c ? '0 :
                               (e_taken[jidx_c] ? e_target[jidx_c] : e_pc[jidx_c] + 32'd4);
        end
    end

    // Entry payload; qualified by the ready flags, so it needs no reset
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && !bus.rollback) begin
            if (alloc_c) begin
                e_pc[tail]    <= bus.dsp_pc;
                e_rd[tail]    <= bus.dsp_rd;
                e_jump[tail]  <= bus.dsp_is_jump;
                e_pred[tail]  <= bus.dsp_pred_taken;
                e_store[tail] <= bus.dsp_is_store;
                e_taken[tail] <= 1'b0;
            end
            if (bus.lsb_valid && bus.lsb_alias != '0 &&
                !(bus.alu_valid && bus.alu_alias == bus.lsb_alias))
                e_val[bus.lsb_alias] <= bus.lsb_val;
            if (bus.alu_valid && bus.alu_alias != '0) begin
                e_val[bus.alu_alias]    <= bus.alu_val;
                e_taken[bus.alu_alias]  <= bus.alu_taken;
                e_target[bus.alu_alias] <= bus.alu_target;
            end
        end
    end
endmodule

// File: tb/tb_rob_wide.sv
// tb_rob_wide: directed self-checking bench for rob_wide (DEPTH=16).
module tb_rob_wide;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    rob_wide_if #(.IDW(4)) bus();
    rob_wide #(.DEPTH(16), .IDW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dsp_valid = 1'b0; bus.dsp_pc = '0; bus.dsp_rd = '0;
        bus.dsp_is_jump = 1'b0; bus.dsp_pred_taken = 1'b0; bus.dsp_is_store = 1'b0;
        bus.q1_alias = '0; bus.q2_alias = '0;
        bus.alu_valid = 1'b0; bus.alu_alias = '0; bus.alu_val = '0;
        bus.alu_taken = 1'b0; bus.alu_target = '0;
        bus.lsb_valid = 1'b0; bus.lsb_alias = '0; bus.lsb_val = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.rdy = 1'b1; idle();
        step();
        rst = 1'b0;
    endtask

    task automatic dsp(input logic [31:0] pc, input logic [4:0] rd,
                       input logic j, input logic p, input logic s);
        bus.dsp_valid = 1'b1; bus.dsp_pc = pc; bus.dsp_rd = rd;
        bus.dsp_is_jump = j; bus.dsp_pred_taken = p; bus.dsp_is_store = s;
        step();
        idle();
    endtask

    // Allocate at tail, complete it on the ALU bus, then let it commit
    task automatic one_shot();
        logic [3:0] a;
        a = bus.dsp_alias;
        dsp(32'h0, 5'd12, 1'b0, 1'b0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_alias = a; bus.alu_val = 32'(a);
        step();
        idle();
        step();
    endtask

    initial begin
        do_reset();
        chk("rst_count", 32'(bus.rob_count), 0);
        chk("rst_full", 32'(bus.rob_full), 0);
        chk("rst_tail", 32'(bus.dsp_alias), 1);
        chk("rst_head", 32'(bus.head_alias), 1);
        chk("rst_wb0v", 32'(bus.wb0_valid), 0);
        chk("rst_rollback", 32'(bus.rollback), 0);
        chk("rst_store", 32'(bus.store_at_head), 0);

        // Fill all 15 entries; aliases must come out 1..15
        for (int i = 0; i < 15; i++) begin
            chk("fill_alias", 32'(bus.dsp_alias), 32'(i + 1));
            dsp(32'h1000 + 32'(4 * i), (i == 0) ? 5'd5 : (i == 1) ? 5'd6 : 5'(i + 10),
                1'b0, 1'b0, 1'b0);
        end
        chk("full_flag", 32'(bus.rob_full), 1);
        chk("full_count", 32'(bus.rob_count), 15);
        chk("full_tail", 32'(bus.dsp_alias), 1);
        dsp(32'hDEAD, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("over_count", 32'(bus.rob_count), 15);
        chk("over_tail", 32'(bus.dsp_alias), 1);

        // Aliases 1 and 2 become ready, dual commit one edge later
        bus.alu_valid = 1'b1; bus.alu_alias = 4'd1; bus.alu_val = 32'hA;
        bus.lsb_valid = 1'b1; bus.lsb_alias = 4'd2; bus.lsb_val = 32'hB;
        step();
        idle();
        chk("cdb_nocommit", 32'(bus.wb0_valid), 0);
        chk("cdb_count", 32'(bus.rob_count), 15);
        step();
        chk("dual_wb0v", 32'(bus.wb0_valid), 1);
        chk("dual_wb0rd", 32'(bus.wb0_rd), 5);
        chk("dual_wb0val", bus.wb0_val, 32'hA);
        chk("dual_wb1v", 32'(bus.wb1_valid), 1);
        chk("dual_wb1rd", 32'(bus.wb1_rd), 6);
        chk("dual_wb1val", bus.wb1_val, 32'hB);
        chk("dual_head", 32'(bus.head_alias), 3);
        chk("dual_count", 32'(bus.rob_count), 13);
        chk("dual_full", 32'(bus.rob_full), 0);
        step();
        chk("quiet_wb0v", 32'(bus.wb0_valid), 0);
        chk("quiet_wb1rd", 32'(bus.wb1_rd), 0);

        // Same rd in both slots: only wb1 writes
        do_reset();
        dsp(32'h40, 5'd7, 1'b0, 1'b0, 1'b0);
        dsp(32'h44, 5'd7, 1'b0, 1'b0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_alias = 4'd1; bus.alu_val = 32'd1;
        bus.lsb_valid = 1'b1; bus.lsb_alias = 4'd2; bus.lsb_val = 32'd2;
        step();
        idle();
        step();
        chk("samerd_wb0v", 32'(bus.wb0_valid), 0);
        chk("samerd_wb1v", 32'(bus.wb1_valid), 1);
        chk("samerd_wb1rd", 32'(bus.wb1_rd), 7);
        chk("samerd_wb1val", bus.wb1_val, 32'd2);
        chk("samerd_count", 32'(bus.rob_count), 0);

        // Mispredicted jump at head: single commit and rollback
        do_reset();
        dsp(32'h200, 5'd1, 1'b1, 1'b0, 1'b0);
        dsp(32'h204, 5'd3, 1'b0, 1'b0, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_alias = 4'd1; bus.alu_val = 32'h204;
        bus.alu_taken = 1'b1; bus.alu_target = 32'h100;
        bus.lsb_valid = 1'b1; bus.lsb_alias = 4'd2; bus.lsb_val = 32'd9;
        step();
        idle();
        step();
        chk("mis_wb0v", 32'(bus.wb0_valid), 1);
        chk("mis_wb0val", bus.wb0_val, 32'h204);
        chk("mis_wb1v", 32'(bus.wb1_valid), 0);
        chk("mis_rollback", 32'(bus.rollback), 1);
        chk("mis_rbpc", bus.rollback_pc, 32'h100);
        chk("mis_pred_en", 32'(bus.pred_en), 1);
        chk("mis_pred_taken", 32'(bus.pred_taken), 0);
        chk("mis_pred_pc", bus.pred_pc, 32'h200);
        chk("mis_count", 32'(bus.rob_count), 1);
        // Allocate and CDB during the rollback cycle are dropped
        bus.dsp_valid = 1'b1; bus.dsp_pc = 32'h999; bus.dsp_rd = 5'd4;
        bus.alu_valid = 1'b1; bus.alu_alias = 4'd2; bus.alu_val = 32'h77;
        step();
        idle();
        chk("rb_count", 32'(bus.rob_count), 0);
        chk("rb_head", 32'(bus.head_alias), 1);
        chk("rb_tail", 32'(bus.dsp_alias), 1);
        chk("rb_clear", 32'(bus.rollback), 0);
        chk("rb_pred_en", 32'(bus.pred_en), 0);

        // Correctly predicted jump: update only, no redirect
        dsp(32'h300, 5'd0, 1'b1, 1'b1, 1'b0);
        bus.alu_valid = 1'b1; bus.alu_alias = 4'd1; bus.alu_val = 32'h304;
        bus.alu_taken = 1'b1; bus.alu_target = 32'h400;
        step();
        idle();
        step();
        chk("hit_pred_en", 32'(bus.pred_en), 1);
        chk("hit_pred_taken", 32'(bus.pred_taken), 1);
        chk("hit_pred_pc", bus.pred_pc, 32'h300);
        chk("hit_rollback", 32'(bus.rollback), 0);
        chk("hit_wb0v_rd0", 32'(bus.wb0_valid), 0);

        // Queries with same-cycle bypass, store at head
        do_reset();
        dsp(32'h10, 5'd8, 1'b0, 1'b0, 1'b1);
        dsp(32'h14, 5'd9, 1'b0, 1'b0, 1'b0);
        dsp(32'h18, 5'd10, 1'b0, 1'b0, 1'b0);
        chk("st_head", 32'(bus.store_at_head), 1);
        chk("st_alias", 32'(bus.head_alias), 1);
        bus.q1_alias = 4'd3; bus.q2_alias = 4'd2;
        bus.alu_valid = 1'b1; bus.alu_alias = 4'd3; bus.alu_val = 32'h55;
        bus.lsb_valid = 1'b1; bus.lsb_alias = 4'd2; bus.lsb_val = 32'h77;
        #1;
        chk("byp_q1rdy", 32'(bus.q1_rdy), 1);
        chk("byp_q1val", bus.q1_val, 32'h55);
        chk("byp_q2rdy", 32'(bus.q2_rdy), 1);
        chk("byp_q2val", bus.q2_val, 32'h77);
        step();
        idle();
        bus.q1_alias = 4'd3; bus.q2_alias = 4'd0;
        #1;
        chk("stored_q1rdy", 32'(bus.q1_rdy), 1);
        chk("stored_q1val", bus.q1_val, 32'h55);
        chk("zero_q2rdy", 32'(bus.q2_rdy), 0);
        chk("zero_q2val", bus.q2_val, 0);
        bus.q1_alias = 4'd1;
        #1;
        chk("pend_q1rdy", 32'(bus.q1_rdy), 0);
        bus.lsb_valid = 1'b1; bus.lsb_alias = 4'd1; bus.lsb_val = 32'h11;
        step();
        idle();
        step();
        chk("st_wb0v", 32'(bus.wb0_valid), 1);
        chk("st_wb0val", bus.wb0_val, 32'h11);
        chk("st_wb1alias", 32'(bus.wb1_alias), 2);
        chk("st_count", 32'(bus.rob_count), 1);
        chk("st_gone", 32'(bus.store_at_head), 0);

        // rdy low: nothing moves, outputs hold
        bus.rdy = 1'b0;
        bus.dsp_valid = 1'b1; bus.dsp_pc = 32'h20; bus.dsp_rd = 5'd2;
        step();
        step();
        idle();
        chk("hold_wb0v", 32'(bus.wb0_valid), 1);
        chk("hold_wb0alias", 32'(bus.wb0_alias), 1);
        chk("hold_wb1val", bus.wb1_val, 32'h77);
        chk("hold_count", 32'(bus.rob_count), 1);
        chk("hold_head", 32'(bus.head_alias), 3);
        bus.rdy = 1'b1;
        step();
        chk("resume_wb0alias", 32'(bus.wb0_alias), 3);
        chk("resume_wb0rd", 32'(bus.wb0_rd), 10);
        chk("resume_wb1v", 32'(bus.wb1_valid), 0);
        chk("resume_count", 32'(bus.rob_count), 0);
        chk("resume_head", 32'(bus.head_alias), 4);

        // Walk head from 4 to 15, then across the wrap
        for (int i = 0; i < 11; i++) one_shot();
        chk("walk_head", 32'(bus.head_alias), 15);
        one_shot();
        chk("wrap_wb0alias", 32'(bus.wb0_alias), 15);
        chk("wrap_head1", 32'(bus.head_alias), 1);
        one_shot();
        chk("wrap_wb0alias2", 32'(bus.wb0_alias), 1);
        chk("wrap_wb0val", bus.wb0_val, 32'd1);
        chk("wrap_head2", 32'(bus.head_alias), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
